// File: rtl/computie_bus_pkg.sv
// rtl/computie_bus_pkg.sv - shared state type and bus direction constants for the Computie bus master
package computie_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    STROBE  = 3'd2,
    DATA    = 3'd3,
    RELEASE = 3'd4
  } bus_master_state_t;

  localparam logic DIR_TO_BUS   = 1'b1;
  localparam logic DIR_FROM_BUS = 1'b0;
  localparam logic BUS_READ     = 1'b1;
  localparam logic BUS_WRITE    = 1'b0;

endpackage

// File: rtl/computie_rr_arbiter.sv
// rtl/computie_rr_arbiter.sv - round-robin picker; the search starts one past the last winner
module computie_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;

  // Pointer starts at the top requester so requester 0 wins first after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (enable && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/computie_bus_master_arb.sv
// rtl/computie_bus_master_arb.sv - arbitrates NUM_REQ requesters onto one Computie bus master port
module computie_bus_master_arb
  import computie_bus_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int NUM_REQ  = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*BITWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BITWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        done,
  output logic                        err,
  output logic [BITWIDTH-1:0]         rdata,
  output logic                        addr_strobe,
  output logic                        read_write,
  input  logic                        dtack_n,
  input  logic [BITWIDTH-1:0]         from_bus,
  output logic [BITWIDTH-1:0]         to_bus,
  output logic                        send_receive,
  output logic                        addr_oe,
  output logic                        data_oe,
  output logic                        data_dir,
  output logic                        demux_oe
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  bus_master_state_t state;
  logic                dtack_meta;
  logic                dtack_s;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                lat_rw;
  logic [BITWIDTH-1:0] lat_wdata;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;

  computie_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .enable      (state == IDLE),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dtack_meta <= 1'b1;
      dtack_s    <= 1'b1;
    end else begin
      dtack_meta <= dtack_n;
      dtack_s    <= dtack_meta;
    end
  end

  assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  // Outputs are written on the transition into each state so every pin is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      to_bus       <= '0;
      addr_strobe  <= 1'b1;
      read_write   <= BUS_READ;
      send_receive <= 1'b0;
      addr_oe      <= 1'b0;
      data_oe      <= 1'b0;
      data_dir     <= DIR_FROM_BUS;
      demux_oe     <= 1'b0;
      cnt          <= '0;
      lat_rw       <= BUS_READ;
      lat_wdata    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant        <= arb_grant;
            lat_rw       <= req_rw[arb_idx];
            lat_wdata    <= req_wdata[arb_idx*BITWIDTH +: BITWIDTH];
            to_bus       <= req_addr[arb_idx*BITWIDTH +: BITWIDTH];
            read_write   <= req_rw[arb_idx];
            send_receive <= 1'b1;
            addr_oe      <= 1'b1;
            demux_oe     <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR: begin
          addr_strobe <= 1'b0;
          state       <= STROBE;
        end
        STROBE: begin
          addr_oe  <= 1'b0;
          data_oe  <= 1'b1;
          data_dir <= (lat_rw == BUS_READ) ? DIR_FROM_BUS : DIR_TO_BUS;
          cnt      <= '0;
          if (lat_rw == BUS_WRITE) begin
            to_bus <= lat_wdata;
          end else begin
            demux_oe     <= 1'b0;
            send_receive <= 1'b0;
          end
          state <= DATA;
        end
        DATA: begin
          cnt <= cnt_next;
          // DTACK is checked first so it wins a tie with the timeout.
          if (!dtack_s || cnt_next == CNT_LIMIT) begin
            if (!dtack_s) begin
              if (lat_rw == BUS_READ) rdata <= from_bus;
            end else begin
              err <= 1'b1;
            end
            done         <= 1'b1;
            addr_strobe  <= 1'b1;
            data_oe      <= 1'b0;
            demux_oe     <= 1'b0;
            addr_oe      <= 1'b0;
            send_receive <= 1'b0;
            grant        <= '0;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          if (dtack_s) begin
            to_bus     <= '0;
            read_write <= BUS_READ;
            data_dir   <= DIR_FROM_BUS;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
